// File: rtl/word_distributor.sv
// Write-side 4-slot distributor: lands a 4-beat valid/ready burst into four slot registers.
// Optional sticky protocol-error output `err` when WORD_DIST_ERR_EN is defined.
module word_distributor #(
  parameter int WIDTH      = 16,
  parameter int FIRST_SLOT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [WIDTH-1:0] out_data4,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic [1:0]       ptr_value,
  output logic             busy,
  output logic             done
`ifdef WORD_DIST_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [1:0] FIRST = 2'(FIRST_SLOT);

  state_t                 state_q, state_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [3:0]             stb_q, stb_d;
  logic [3:0][WIDTH-1:0]  slot_q;
  logic                   accept;

  assign accept = (state_q == RECV) && in_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    stb_d   = 4'b0000;
    case (state_q)
      IDLE: if (start) begin
        state_d = RECV;
        ptr_d   = FIRST;
        cnt_d   = 2'd0;
      end
      RECV: if (accept) begin
        stb_d = 4'b0001 << ptr_q;
        ptr_d = ptr_q + 2'd1;
        cnt_d = cnt_q + 2'd1;
        // count wraps to 0 on the 4th beat, leaving it ready for the next burst
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= FIRST;
      cnt_q   <= 2'd0;
      stb_q   <= 4'b0000;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      if (accept) slot_q[ptr_q] <= in_data;
    end
  end

`ifdef WORD_DIST_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if ((in_valid && (state_q != RECV)) || (start && (state_q == RECV)))
      err_q <= 1'b1;
  end
  assign err = err_q;
`endif

  assign in_ready  = (state_q == RECV);
  assign busy      = (state_q == RECV);
  assign done      = (state_q == DONE);
  assign ptr_value = ptr_q;
  assign {d, c, b, a} = stb_q;
  assign out_data1 = slot_q[0];
  assign out_data2 = slot_q[1];
  assign out_data3 = slot_q[2];
  assign out_data4 = slot_q[3];

endmodule
